demux1x32_collector: RTL

//  - Serial-to-parallel collector; the inverse of the 32:1 mux stepped by a select counter.
//  - One bit per accepted cycle is demultiplexed into slot s of a WIDTH-bit shadow register.
//  - s increments after each accepted bit. After WIDTH bits the assembled word is published on D with a 1-cycle done pulse.
//  - Sits at the receive end of a link driven by the mux + select counter, and rebuilds the original D word.

---
 rtl/demux1x32_collector.sv | 88 ++++++++
 1 files changed

// File: rtl/demux1x32_collector.sv
// demux1x32_collector: serial-to-parallel collector.
// One accepted bit per cycle fills slot s of a shadow register (LSB first);
// after WIDTH bits the assembled word is published on D with a 1-cycle done.
// Optional feature macro: DEMUX_PARITY_EN adds an even-parity output that
// tracks D. Without the macro the parity port and its logic are absent.
module demux1x32_collector #(
   parameter int WIDTH = 32,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             din,
   input  logic             din_valid,
   output logic [SEL_W-1:0] s,
   output logic [WIDTH-1:0] D,
   output logic             done
`ifdef DEMUX_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

   // Only slots 0..WIDTH-2 need storage: the final bit goes straight from
   // din into D on the completion edge.
   logic [WIDTH-2:0] shadow;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] word_next;

   // A bit is taken only when enabled, valid and not being flushed.
   always_comb begin
      accept    = en && din_valid && !clr;
      last_bit  = accept && (s == LAST_SLOT);
      word_next = {din, shadow};
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_slot
         // Capture the accepted bit into the slot the select currently points at.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shadow[gi] <= 1'b0;
            end else if (accept && (s == SEL_W'(gi))) begin
               shadow[gi] <= din;
            end
         end
      end
   endgenerate

   // Select counter, word publication and the one-cycle completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s    <= '0;
         D    <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (en) begin
            if (clr) begin
               s <= '0;
            end else if (din_valid) begin
               s <= s + SEL_W'(1);
               if (last_bit) begin
                  D    <= word_next;
                  done <= 1'b1;
               end
            end
         end
      end
   end

`ifdef DEMUX_PARITY_EN
   // Parity is refreshed together with D so the pair always describes the same word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity <= 1'b0;
      end else if (last_bit) begin
         parity <= ^word_next;
      end
   end
`endif

endmodule
